writeback_queue: RTL

//  Write-side partner of the register file: collects completed results from the ALU and

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 41 ++++
 rtl/writeback_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue.
//   WB_ADDR_W  : register index width (32 architectural registers)
//   WB_DATA_W  : result width
//   wb_entry_t : one pending register-file write {index, value}
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] index;
    logic [WB_DATA_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding priority search over N pending writes.
// Entry 0 is the oldest, entry N-1 the youngest; the youngest valid entry whose
// index matches the lookup wins. Index 0 (the hardwired zero register) never hits.
// Ports:
//   lookup_index : register being looked up
//   entries      : pending writes, ordered oldest (0) to youngest (N-1)
//   valid        : per-entry valid
//   hit          : some valid entry matches
//   value        : data of the youngest match, 0 on no hit
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [WB_ADDR_W-1:0] lookup_index,
  input  wb_entry_t [N-1:0]    entries,
  input  logic [N-1:0]         valid,
  output logic                 hit,
  output logic [WB_DATA_W-1:0] value
);

  logic [N-1:0] match;

  for (genvar gi = 0; gi < N; gi++) begin : g_match
    assign match[gi] = valid[gi] && (entries[gi].index == lookup_index) &&
                       (lookup_index != '0);
  end

  // Ascending scan: a later (younger) match overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = 0; i < N; i++) begin
      if (match[i]) begin
        hit   = 1'b1;
        value = entries[i].value;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers completed ALU and memory results in acceptance order and
// retires one register-file write per cycle. Also offers two forwarding lookups over
// the write currently on the WB port plus every queued entry.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   memValid/memIndex/memValue      : memory-pipe result in,  memReady out
//   aluValid/aluIndex/aluValue      : ALU result in,          aluReady out
//   regWriteW/indexWB/valueInput    : register-file write port (one-cycle strobe)
//   fwdIndex1/2 -> fwdHit1/2, fwdValue1/2 : forwarding lookups
//   empty                           : nothing queued and nothing on the WB port
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memIndex,
  input  logic [DATA_W-1:0] memValue,
  output logic              memReady,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluIndex,
  input  logic [DATA_W-1:0] aluValue,
  output logic              aluReady,
  output logic              regWriteW,
  output logic [ADDR_W-1:0] indexWB,
  output logic [DATA_W-1:0] valueInput,
  input  logic [ADDR_W-1:0] fwdIndex1,
  input  logic [ADDR_W-1:0] fwdIndex2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdValue1,
  output logic [DATA_W-1:0] fwdValue2,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wb_valid_q, wb_valid_d;
  wb_entry_t        wb_q, wb_d;

  logic             mem_acc;
  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W:0]   count_ext;

  // Ready looks only at the registered count, so a full queue refuses input even
  // when it is popping in the same cycle. The ALU sees one slot less whenever the
  // memory pipe takes one, since the memory result is enqueued first.
  assign count_ext = {1'b0, count_q};
  assign memReady  = count_ext < DEPTH_C;
  assign mem_acc   = memValid & memReady;
  assign aluReady  = (count_ext + {{CNT_W{1'b0}}, mem_acc}) < DEPTH_C;

  // Writes to register 0 complete the handshake but are discarded.
  assign mem_push = mem_acc & (memIndex != '0);
  assign alu_push = aluValid & aluReady & (aluIndex != '0);
  assign pop      = count_q != '0;
  assign alu_slot = wr_ptr_q + PTR_W'(mem_push);

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(mem_push) + PTR_W'(alu_push);
    count_d    = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    wb_valid_d = pop;
    wb_d       = wb_q;
    if (pop) begin
      wb_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  // Entry contents need no reset: validity is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      mem_q[wr_ptr_q] <= '{index: memIndex, value: memValue};
    end
    if (alu_push) begin
      mem_q[alu_slot] <= '{index: aluIndex, value: aluValue};
    end
  end

  assign regWriteW  = wb_valid_q;
  assign indexWB    = wb_q.index;
  assign valueInput = wb_q.value;
  assign empty      = (count_q == '0) & ~wb_valid_q;

  // Forwarding view ordered oldest to youngest: the WB output register first,
  // then queue entries from head towards tail.
  wb_entry_t [DEPTH:0] fwd_entries;
  logic [DEPTH:0]      fwd_valid;

  assign fwd_entries[0] = wb_q;
  assign fwd_valid[0]   = wb_valid_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] slot;
    assign slot               = rd_ptr_q + PTR_W'(gi);
    assign fwd_entries[gi+1]  = mem_q[slot];
    assign fwd_valid[gi+1]    = CNT_W'(gi) < count_q;
  end

  wb_fwd_match #(.N(DEPTH + 1)) u_fwd1 (
    .lookup_index (fwdIndex1),
    .entries      (fwd_entries),
    .valid        (fwd_valid),
    .hit          (fwdHit1),
    .value        (fwdValue1)
  );

  wb_fwd_match #(.N(DEPTH + 1)) u_fwd2 (
    .lookup_index (fwdIndex2),
    .entries      (fwd_entries),
    .valid        (fwd_valid),
    .hit          (fwdHit2),
    .value        (fwdValue2)
  );

endmodule
